// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared slot record, sizing helpers and screen constants for the sprite layer
package sprite_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int rom_aw(input int num_img, input int frames, input int h, input int w);
        return clog2_min1(num_img * frames * h * w);
    endfunction

    // img/frame are held at a fixed 8-bit width so the record does not depend on module parameters
    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] img;
        logic [7:0] frame;
        logic       en;
        logic       anim;
`ifdef SPRITE_FLIP_EN
        logic       flip;
`endif
    } slot_t;

endpackage

// File: rtl/sprite_slot_hit.sv
// rtl/sprite_slot_hit.sv - bounding-box hit test and source-pixel offsets for one sprite slot
module sprite_slot_hit #(
    parameter int SPR_W      = 20,
    parameter int SPR_H      = 20,
    parameter int SCALE_LOG2 = 0
) (
    input  logic [9:0]  draw_x_i,
    input  logic [9:0]  draw_y_i,
    input  logic [9:0]  slot_x_i,
    input  logic [9:0]  slot_y_i,
    input  logic        en_i,
    output logic        hit_o,
    output logic [10:0] dx_o,
    output logic [10:0] dy_o
);

    logic [10:0] diff_x;
    logic [10:0] diff_y;

    // 11-bit unsigned differences: a pixel left of / above the slot wraps to a huge value and misses
    assign diff_x = {1'b0, draw_x_i} - {1'b0, slot_x_i};
    assign diff_y = {1'b0, draw_y_i} - {1'b0, slot_y_i};

    assign hit_o = en_i
                 && (diff_x < 11'(SPR_W << SCALE_LOG2))
                 && (diff_y < 11'(SPR_H << SCALE_LOG2));
    assign dx_o  = diff_x >> SCALE_LOG2;
    assign dy_o  = diff_y >> SCALE_LOG2;

endmodule

// File: rtl/sprite_layer_renderer.sv
// rtl/sprite_layer_renderer.sv - NUM_SLOTS animated sprites over one ROM, 3-stage pixel pipeline; SPRITE_FLIP_EN adds cfg_flip
module sprite_layer_renderer
    import sprite_pkg::*;
#(
    parameter int NUM_SLOTS  = 4,
    parameter int SPR_W      = 20,
    parameter int SPR_H      = 20,
    parameter int NUM_IMG    = 4,
    parameter int FRAMES     = 2,
    parameter int SCALE_LOG2 = 0,
    parameter int ANIM_DIV   = 8,
    parameter int IDX_W      = 8,
    parameter int TRANSP_IDX = 0,
    localparam int SLOT_W    = clog2_min1(NUM_SLOTS),
    localparam int IMG_W     = clog2_min1(NUM_IMG),
    localparam int ROM_AW    = rom_aw(NUM_IMG, FRAMES, SPR_H, SPR_W)
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic              vsync,
    input  logic              cfg_we,
    input  logic [SLOT_W-1:0] cfg_slot,
    input  logic [9:0]        cfg_x,
    input  logic [9:0]        cfg_y,
    input  logic [IMG_W-1:0]  cfg_img,
    input  logic              cfg_en,
    input  logic              cfg_anim,
`ifdef SPRITE_FLIP_EN
    input  logic              cfg_flip,
`endif
    output logic [ROM_AW-1:0] rom_address,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [IDX_W-1:0]  pal_index,
    input  logic [3:0]        pal_red,
    input  logic [3:0]        pal_green,
    input  logic [3:0]        pal_blue,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              sprite_on
);

    localparam int DIV_W = clog2_min1(ANIM_DIV);

    slot_t             slots_q [NUM_SLOTS];
    slot_t             slots_d [NUM_SLOTS];
    logic              vsync_q;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              vs_fall, anim_step;

    logic              hit_w [NUM_SLOTS];
    logic [10:0]       dx_w  [NUM_SLOTS];
    logic [10:0]       dy_w  [NUM_SLOTS];

    logic              sel_hit;
    logic [10:0]       sel_dx, sel_dy, dx_eff;
    logic [7:0]        sel_img, sel_frame;
`ifdef SPRITE_FLIP_EN
    logic              sel_flip;
`endif

    logic [ROM_AW-1:0] addr_q, addr_d;
    logic              hit0_q, blank0_q, hit1_q, blank1_q;
    logic [3:0]        red_q, green_q, blue_q, red_d, green_d, blue_d;
    logic              on_q, on_d;

    assign vs_fall   = vsync_q & ~vsync;
    assign anim_step = vs_fall && (div_q == DIV_W'(ANIM_DIV - 1));

    always_comb begin
        div_d = div_q;
        if (vs_fall) div_d = anim_step ? '0 : div_q + 1'b1;
    end

    // Slot update: animation first, then a config write overrides it for the addressed slot
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slots_d[i] = slots_q[i];
            if (anim_step && slots_q[i].anim)
                slots_d[i].frame = (slots_q[i].frame >= 8'(FRAMES - 1)) ? 8'd0 : slots_q[i].frame + 8'd1;
            if (cfg_we && (32'(cfg_slot) == i)) begin
                slots_d[i].x     = cfg_x;
                slots_d[i].y     = cfg_y;
                slots_d[i].img   = 8'(cfg_img);
                slots_d[i].frame = 8'd0;
                slots_d[i].en    = cfg_en;
                slots_d[i].anim  = cfg_anim;
`ifdef SPRITE_FLIP_EN
                slots_d[i].flip  = cfg_flip;
`endif
            end
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        sprite_slot_hit #(
            .SPR_W      (SPR_W),
            .SPR_H      (SPR_H),
            .SCALE_LOG2 (SCALE_LOG2)
        ) u_hit (
            .draw_x_i (DrawX),
            .draw_y_i (DrawY),
            .slot_x_i (slots_q[g].x),
            .slot_y_i (slots_q[g].y),
            .en_i     (slots_q[g].en),
            .hit_o    (hit_w[g]),
            .dx_o     (dx_w[g]),
            .dy_o     (dy_w[g])
        );
    end

    // Walk from the top index down so the lowest-index hit is the one left standing
    always_comb begin
        sel_hit   = 1'b0;
        sel_dx    = '0;
        sel_dy    = '0;
        sel_img   = '0;
        sel_frame = '0;
`ifdef SPRITE_FLIP_EN
        sel_flip  = 1'b0;
`endif
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (hit_w[i]) begin
                sel_hit   = 1'b1;
                sel_dx    = dx_w[i];
                sel_dy    = dy_w[i];
                sel_img   = slots_q[i].img;
                sel_frame = slots_q[i].frame;
`ifdef SPRITE_FLIP_EN
                sel_flip  = slots_q[i].flip;
`endif
            end
        end
        dx_eff = sel_dx;
`ifdef SPRITE_FLIP_EN
        if (sel_flip) dx_eff = 11'(SPR_W - 1) - sel_dx;
`endif
        addr_d = '0;
        if (sel_hit)
            addr_d = ROM_AW'(((32'(sel_img) * FRAMES + 32'(sel_frame)) * SPR_H + 32'(sel_dy)) * SPR_W + 32'(dx_eff));
    end

    assign pal_index = rom_q;

    always_comb begin
        red_d   = 4'd0;
        green_d = 4'd0;
        blue_d  = 4'd0;
        on_d    = 1'b0;
        if (hit1_q && blank1_q && (rom_q != IDX_W'(TRANSP_IDX))) begin
            red_d   = pal_red;
            green_d = pal_green;
            blue_d  = pal_blue;
            on_d    = 1'b1;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) slots_q[i] <= '0;
            vsync_q  <= 1'b0;
            div_q    <= '0;
            addr_q   <= '0;
            hit0_q   <= 1'b0;
            blank0_q <= 1'b0;
            hit1_q   <= 1'b0;
            blank1_q <= 1'b0;
            red_q    <= 4'd0;
            green_q  <= 4'd0;
            blue_q   <= 4'd0;
            on_q     <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) slots_q[i] <= slots_d[i];
            vsync_q  <= vsync;
            div_q    <= div_d;
            addr_q   <= addr_d;
            hit0_q   <= sel_hit;
            blank0_q <= blank;
            hit1_q   <= hit0_q;
            blank1_q <= blank0_q;
            red_q    <= red_d;
            green_q  <= green_d;
            blue_q   <= blue_d;
            on_q     <= on_d;
        end
    end

    assign rom_address = addr_q;
    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;
    assign sprite_on   = on_q;

endmodule

// File: doc/sprite_layer_renderer.md
Name: sprite_layer_renderer

Overview:
Parametrised successor to the single-sprite ROM/palette renderer. Holds NUM_SLOTS independently positioned, animated sprite instances that share one sprite-sheet ROM. Per VGA pixel it does a bounding-box hit test, picks the highest-priority slot, and fetches the ROM index. It then resolves colour through the palette and applies a transparency key. Sits between the VGA controller (DrawX/DrawY/blank/vsync) and the top-level colour mux, and emits an RGB pixel plus a sprite_on flag.

Parameters:
NUM_SLOTS, 4, number of sprite instances
SPR_W, 20, sprite width in source pixels
SPR_H, 20, sprite height in source pixels
NUM_IMG, 4, distinct images in the sheet
FRAMES, 2, animation frames per image
SCALE_LOG2, 0, on-screen magnification 2^SCALE_LOG2
ANIM_DIV, 8, vsync pulses per animation step
IDX_W, 8, ROM data / palette index width
TRANSP_IDX, 0, palette index treated as transparent

Ports:
vga_clk  in  1  pixel clock; all logic on posedge
reset_n  in  1  synchronous active-low reset
DrawX  in  10  current pixel column
DrawY  in  10  current pixel row
blank  in  1  1 = active video (VGA controller convention)
vsync  in  1  vertical sync, active low
cfg_we  in  1  slot register write strobe
cfg_slot  in  clog2(NUM_SLOTS)  slot written
cfg_x  in  10  slot left edge
cfg_y  in  10  slot top edge
cfg_img  in  clog2(NUM_IMG)  image select
cfg_en  in  1  slot visible
cfg_anim  in  1  slot animates
rom_address  out  ROM_AW  sprite-sheet ROM address; ROM_AW = clog2(NUM_IMG*FRAMES*SPR_H*SPR_W)
rom_q  in  IDX_W  ROM data, registered, valid 1 cycle after address
pal_index  out  IDX_W  palette lookup index (combinational palette)
pal_red/pal_green/pal_blue  in  4 each  palette colour
red/green/blue  out  4 each  output colour
sprite_on  out  1  opaque sprite pixel present

Behaviour:
- Reset (reset_n=0 at posedge): all slots get en=0, x=y=0, img=0, frame=0; vsync divider=0; pipeline valid bits=0; red/green/blue=0, sprite_on=0, rom_address=0.
- Config: cfg_we writes all fields of cfg_slot at that posedge; the new value takes effect from the next pixel entering S0. Writing a slot resets its frame to 0. An out-of-range cfg_slot is ignored.
- Pipeline, fixed latency 3: DrawX/DrawY/blank at edge t produce red/green/blue/sprite_on at edge t+3.
  - S0: for each enabled slot, hit = DrawX-x in [0, SPR_W<<SCALE_LOG2) and DrawY-y in [0, SPR_H<<SCALE_LOG2), using unsigned 11-bit differences so no wrap at screen edges. The lowest-index hit wins. dx = (DrawX-x)>>SCALE_LOG2, same for dy. Register rom_address = ((img*FRAMES+frame)*SPR_H+dy)*SPR_W+dx, plus hit and blank.
  - S1: ROM read; hit and blank are delayed one stage.
  - S2: pal_index=rom_q. If hit & blank & rom_q!=TRANSP_IDX, register palette RGB and set sprite_on=1. Otherwise output 0 and sprite_on=0.
- Transparency does not reveal lower-priority slots; priority is decided on the bounding box only.
- Animation: a falling vsync edge is detected against a registered copy of vsync. Every ANIM_DIV edges, each slot with anim=1 advances frame = (frame+1) mod FRAMES. Slots with anim=0 hold their frame. With FRAMES=1, frame is always 0.
- A config write and an animation step on the same cycle: the write wins for that slot.
- Reset mid-frame: outputs are 0 on the next cycle. Valid output resumes 3 cycles after reset_n rises.

Optional Feature:
SPRITE_FLIP_EN. When defined, an extra port cfg_flip (in, 1) and a per-slot flip bit exist (reset 0). With flip=1, dx becomes SPR_W-1-dx before address formation. When undefined, the port and bit are absent and the address is unmodified.

Decomposition:
- Package sprite_pkg holds:
  - the slot record typedef (x, y, img, frame, en, anim, flip);
  - the clog2 helpers;
  - the ROM_AW function;
  - screen constants 640/480.
- Sub-module sprite_slot_hit: combinational hit/dx/dy for one slot, instantiated NUM_SLOTS times via generate.
- The ROM and palette stay external.

Test Plan:
- Reset, then slot0 at (100,50), img0, en. Drive DrawX=100, DrawY=50, blank=1. rom_address=0 one cycle later; 3 cycles later RGB = palette(rom_q) and sprite_on=1.
- DrawX=119,DrawY=69 gives address 399. DrawX=120 gives sprite_on=0 at t+3.
- Slots 0 and 1 overlap at (200,200). Slot 0 is selected; when rom_q=TRANSP_IDX, sprite_on=0 and slot 1 is not shown.
- ANIM_DIV=8, FRAMES=2, anim=1. After 8 vsync falls the address offset is +SPR_W*SPR_H; after 16 it is back to base.
- SCALE_LOG2=1 with slot at (0,0). DrawX=3,DrawY=5 gives dx=1, dy=2, address=41.
- blank=0 inside the sprite gives RGB=0 and sprite_on=0. Pulse reset_n low mid-line: outputs are 0 the next cycle.
